// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out reading a 160x120 RGB332 framebuffer, each pixel scaled 4x4.
// Define VGA_TEST_PATTERN_EN to replace memory data with an (h>>2)^(v>>2) test pattern.
module vga_scanout #(
   parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   output logic [31:0] addr_vga,
   input  logic [31:0] read_data_vga,
   output logic        vga_clk,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [2:0]  vga_r,
   output logic [2:0]  vga_g,
   output logic [1:0]  vga_b,
   output logic        frame_start
);

   localparam logic [9:0] H_VIS    = 10'd640;
   localparam logic [9:0] H_SYNC_S = 10'd656;
   localparam logic [9:0] H_SYNC_E = 10'd751;
   localparam logic [9:0] H_LAST   = 10'd799;
   localparam logic [9:0] V_VIS    = 10'd480;
   localparam logic [9:0] V_SYNC_S = 10'd490;
   localparam logic [9:0] V_SYNC_E = 10'd491;
   localparam logic [9:0] V_LAST   = 10'd524;

   logic       pe_reg;
   logic [9:0] h_reg;
   logic [9:0] v_reg;
   logic [9:0] h_next;
   logic [9:0] v_next;

   // Decode of the counter state whose word is in flight; consumed one tick later.
   logic       st_hs_n;
   logic       st_vs_n;
   logic       st_vis;
   logic [1:0] st_lane;
`ifdef VGA_TEST_PATTERN_EN
   logic [7:0] st_pat;
`endif

   logic        visible;
   logic        hs_act;
   logic        vs_act;
   logic [31:0] fetch_addr;
   logic [7:0]  pix_byte;

   assign visible = (h_reg < H_VIS) && (v_reg < V_VIS);
   assign hs_act  = (h_reg >= H_SYNC_S) && (h_reg <= H_SYNC_E);
   assign vs_act  = (v_reg >= V_SYNC_S) && (v_reg <= V_SYNC_E);

   assign h_next = (h_reg == H_LAST) ? 10'd0 : h_reg + 10'd1;
   assign v_next = (h_reg != H_LAST) ? v_reg :
                   (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;

   // Row stride 160 bytes per framebuffer line; one 32-bit word covers 16 screen columns.
   assign fetch_addr = FB_BASE + 32'(v_reg[9:2]) * 32'd160 + {24'd0, h_reg[9:4], 2'b00};

`ifdef VGA_TEST_PATTERN_EN
   assign pix_byte = st_pat;
`else
   assign pix_byte = read_data_vga[{st_lane, 3'b000} +: 8];
`endif

   assign vga_clk = pe_reg;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pe_reg      <= 1'b0;
         h_reg       <= 10'd0;
         v_reg       <= 10'd0;
         addr_vga    <= FB_BASE;
         st_hs_n     <= 1'b1;
         st_vs_n     <= 1'b1;
         st_vis      <= 1'b0;
         st_lane     <= 2'd0;
`ifdef VGA_TEST_PATTERN_EN
         st_pat      <= 8'd0;
`endif
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= 3'd0;
         vga_g       <= 3'd0;
         vga_b       <= 2'd0;
         frame_start <= 1'b0;
      end else begin
         pe_reg      <= ~pe_reg;
         frame_start <= 1'b0;
         if (pe_reg) begin
            h_reg    <= h_next;
            v_reg    <= v_next;
            addr_vga <= fetch_addr;
            st_hs_n  <= ~hs_act;
            st_vs_n  <= ~vs_act;
            st_vis   <= visible;
            st_lane  <= h_reg[3:2];
`ifdef VGA_TEST_PATTERN_EN
            st_pat   <= h_reg[9:2] ^ v_reg[9:2];
`endif
            // Memory data for st_* arrived one clock after the address was issued.
            vga_hs      <= st_hs_n;
            vga_vs      <= st_vs_n;
            vga_blank_n <= st_vis;
            vga_r       <= st_vis ? pix_byte[7:5] : 3'd0;
            vga_g       <= st_vis ? pix_byte[4:2] : 3'd0;
            vga_b       <= st_vis ? pix_byte[1:0] : 2'd0;
            frame_start <= (h_reg == H_LAST) && (v_reg == V_LAST);
         end
      end
   end

endmodule
